// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Accumulates PP_PER_CYCLE partial products per clock, with valid/ready handshakes on both sides.
module booth_r4_seq_mult #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned PP_PER_CYCLE = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_multa_ns,
  input  logic               i_multb_ns,
  input  logic [WIDTH-1:0]   i_multa,
  input  logic [WIDTH-1:0]   i_multb,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [2*WIDTH-1:0] o_product,
  output logic               o_signed,
  output logic               o_busy
);

  localparam int unsigned NPP = WIDTH / 2 + 1;
  localparam int unsigned AW  = 2 * WIDTH + 2;
  localparam int unsigned CW  = $clog2(NPP + 1);
  localparam logic [CW-1:0] LastCnt = CW'(NPP - PP_PER_CYCLE);
  localparam logic [CW-1:0] CntStep = CW'(PP_PER_CYCLE);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH+1:0]   x_q;
  logic [WIDTH+2:0]   y_q;
  logic [CW-1:0]      cnt_q;
  logic [AW-1:0]      acc_q, acc_sum;
  logic               sgn_q;
  logic [2*WIDTH-1:0] product_q;
  logic               signed_q;
  logic               accept, last;

  assign accept = (state_q == StIdle) & i_valid & ~i_clr;
  assign last   = (cnt_q == LastCnt);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_clr) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (i_valid) state_d = StCalc;
        StCalc:  if (last)    state_d = StDone;
        StDone:  if (i_ready) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    o_ready   = (state_q == StIdle);
    o_valid   = (state_q == StDone);
    o_busy    = (state_q != StIdle);
    o_product = product_q;
    o_signed  = signed_q;
  end

  // Booth digits cnt .. cnt+PP_PER_CYCLE-1, each scaled by 4^k into the accumulator.
  logic [AW-1:0] xe, pp;
  logic [2:0]    trip;
  int unsigned   sh;

  always_comb begin
    acc_sum = acc_q;
    xe      = {{WIDTH{x_q[WIDTH+1]}}, x_q};
    pp      = '0;
    trip    = '0;
    sh      = 0;
    for (int unsigned j = 0; j < PP_PER_CYCLE; j++) begin
      sh   = 2 * (32'(cnt_q) + j);
      trip = 3'(y_q >> sh);
      unique case (trip)
        3'b001, 3'b010: pp = xe;
        3'b101, 3'b110: pp = -xe;
        3'b011:         pp = xe << 1;
        3'b100:         pp = -(xe << 1);
        default:        pp = '0;
      endcase
      acc_sum = acc_sum + (pp << sh);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q       <= '0;
      y_q       <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      sgn_q     <= 1'b0;
      product_q <= '0;
      signed_q  <= 1'b0;
    end else if (accept) begin
      x_q   <= {{2{i_multa_ns & i_multa[WIDTH-1]}}, i_multa};
      y_q   <= {{2{i_multb_ns & i_multb[WIDTH-1]}}, i_multb, 1'b0};
      cnt_q <= '0;
      acc_q <= '0;
      sgn_q <= i_multa_ns | i_multb_ns;
    end else if (!i_clr && state_q == StCalc) begin
      acc_q <= acc_sum;
      cnt_q <= cnt_q + CntStep;
      if (last) begin
        product_q <= acc_sum[2*WIDTH-1:0];
        signed_q  <= sgn_q;
      end
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Self-checking bench for booth_r4_seq_mult: directed corner cases plus randomized
// traffic against an arithmetic reference model.
module tb_booth_r4_seq_mult;

  localparam int NRAND = 2500;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 16x16, one partial product per cycle
  logic        clr, valid, rdy, an, bn;
  logic [15:0] a, b;
  logic        ready, pvalid, prod_signed, busy;
  logic [31:0] product;

  // 16x16, three partial products per cycle
  logic        p3_valid, p3_rdy;
  logic [15:0] p3_a, p3_b;
  logic        p3_ready, p3_pvalid, p3_signed, p3_busy;
  logic [31:0] p3_product;

  // 8x8, five partial products per cycle
  logic        w8_valid, w8_rdy;
  logic [7:0]  w8_a, w8_b;
  logic        w8_ready, w8_pvalid, w8_signed, w8_busy;
  logic [15:0] w8_product;

  int errors = 0;
  int checks = 0;

  booth_r4_seq_mult #(.WIDTH(16), .PP_PER_CYCLE(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_valid(valid), .o_ready(ready),
    .i_multa_ns(an), .i_multb_ns(bn), .i_multa(a), .i_multb(b),
    .o_valid(pvalid), .i_ready(rdy), .o_product(product), .o_signed(prod_signed), .o_busy(busy)
  );

  booth_r4_seq_mult #(.WIDTH(16), .PP_PER_CYCLE(3)) dut_p3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(1'b0), .i_valid(p3_valid), .o_ready(p3_ready),
    .i_multa_ns(1'b0), .i_multb_ns(1'b0), .i_multa(p3_a), .i_multb(p3_b),
    .o_valid(p3_pvalid), .i_ready(p3_rdy), .o_product(p3_product), .o_signed(p3_signed),
    .o_busy(p3_busy)
  );

  booth_r4_seq_mult #(.WIDTH(8), .PP_PER_CYCLE(5)) dut_w8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(1'b0), .i_valid(w8_valid), .o_ready(w8_ready),
    .i_multa_ns(1'b1), .i_multb_ns(1'b1), .i_multa(w8_a), .i_multb(w8_b),
    .o_valid(w8_pvalid), .i_ready(w8_rdy), .o_product(w8_product), .o_signed(w8_signed),
    .o_busy(w8_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Exact product of the operands as interpreted by their mode flags, truncated to 32 bits.
  function automatic logic [31:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic sa, input logic sb);
    longint xa, xb, p;
    xa = sa ? longint'($signed(ma)) : longint'(ma);
    xb = sb ? longint'($signed(mb)) : longint'(mb);
    p  = xa * xb;
    return p[31:0];
  endfunction

  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tbv,
                        input logic tan, input logic tbn, input logic [31:0] ep,
                        input logic es);
    int lat, g;
    a = ta; b = tbv; an = tan; bn = tbn;
    g = 0;
    while (!ready && g < 100) begin tick(); g++; end
    valid = 1'b1;
    tick();
    valid = 1'b0;
    lat = 0;
    while (!pvalid && lat < 100) begin tick(); lat++; end
    check({tag, "_lat"}, 64'(lat), 64'd9);
    check({tag, "_prod"}, 64'(product), 64'(ep));
    check({tag, "_sgn"}, 64'(prod_signed), 64'(es));
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    check({tag, "_rdy_after"}, 64'({ready, pvalid}), 64'b10);
  endtask

  logic [32:0] exp_q[$];
  int          got_cnt;

  initial begin
    logic [31:0] held;
    int          lat, spurious;

    rst_n = 1'b0; clr = 1'b0; valid = 1'b0; rdy = 1'b0; an = 1'b0; bn = 1'b0; a = '0; b = '0;
    p3_valid = 1'b0; p3_rdy = 1'b0; p3_a = '0; p3_b = '0;
    w8_valid = 1'b0; w8_rdy = 1'b0; w8_a = '0; w8_b = '0;
    #12;
    check("reset_ctrl", 64'({ready, pvalid, busy, prod_signed}), 64'b1000);
    check("reset_prod", 64'(product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_reset_ctrl", 64'({ready, pvalid, busy}), 64'b100);

    // Corner products
    run_op("uu_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'hFFFE0001, 1'b0);
    run_op("ss_ffff", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 32'h00000001, 1'b1);
    run_op("su_ffff", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 32'hFFFF0001, 1'b1);
    run_op("ss_8000", 16'h8000, 16'h8000, 1'b1, 1'b1, 32'h40000000, 1'b1);
    run_op("ss_7fff", 16'h7FFF, 16'h8000, 1'b1, 1'b1, 32'hC0008000, 1'b1);

    // PP_PER_CYCLE=3
    p3_a = 16'h1234; p3_b = 16'h5678; p3_valid = 1'b1;
    tick();
    p3_valid = 1'b0;
    lat = 0;
    while (!p3_pvalid && lat < 50) begin tick(); lat++; end
    check("p3_lat", 64'(lat), 64'd3);
    check("p3_prod", 64'(p3_product), 64'h06260060);
    check("p3_sgn", 64'(p3_signed), 64'd0);
    p3_rdy = 1'b1; tick(); p3_rdy = 1'b0;
    check("p3_rdy_after", 64'({p3_ready, p3_pvalid, p3_busy}), 64'b100);

    // WIDTH=8, PP_PER_CYCLE=5
    w8_a = 8'h80; w8_b = 8'h7F; w8_valid = 1'b1;
    tick();
    w8_valid = 1'b0;
    lat = 0;
    while (!w8_pvalid && lat < 50) begin tick(); lat++; end
    check("w8_lat", 64'(lat), 64'd1);
    check("w8_prod", 64'(w8_product), 64'hC080);
    check("w8_sgn", 64'(w8_signed), 64'd1);
    w8_rdy = 1'b1; tick(); w8_rdy = 1'b0;
    check("w8_rdy_after", 64'({w8_ready, w8_pvalid, w8_busy}), 64'b100);

    // Backpressure: 20 stalled cycles with fresh requests that must be ignored
    a = 16'h1234; b = 16'h0002; an = 1'b0; bn = 1'b0; valid = 1'b1;
    tick();
    valid = 1'b0;
    lat = 0;
    while (!pvalid && lat < 100) begin tick(); lat++; end
    held = product;
    check("bp_prod", 64'(held), 64'h2468);
    for (int i = 0; i < 20; i++) begin
      a = 16'(i + 3); b = 16'hBEEF; an = 1'b1; valid = 1'b1;
      tick();
      check("bp_hold_ctrl", 64'({pvalid, ready}), 64'b10);
      check("bp_hold_prod", 64'(product), 64'(held));
    end
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    check("bp_release", 64'({ready, pvalid, busy}), 64'b100);
    valid = 1'b0;

    // Abort in the 4th CALC cycle with a simultaneous request
    a = 16'h0007; b = 16'h0009; an = 1'b0; bn = 1'b0; valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (3) tick();
    check("abort_pre_busy", 64'(busy), 64'd1);
    clr = 1'b1; valid = 1'b1; a = 16'h00AA;
    tick();
    clr = 1'b0; valid = 1'b0;
    check("abort_ctrl", 64'({ready, pvalid, busy}), 64'b100);
    check("abort_prod_kept", 64'(product), 64'(held));
    spurious = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (pvalid || busy) spurious++;
    end
    check("abort_no_pulse", 64'(spurious), 64'd0);
    run_op("after_abort", 16'd3, 16'd5, 1'b0, 1'b0, 32'h0000000F, 1'b0);

    // Asynchronous reset mid-CALC
    a = 16'h4321; b = 16'h1111; valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (3) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("areset_ctrl", 64'({ready, pvalid, busy, prod_signed}), 64'b1000);
    check("areset_prod", 64'(product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op("after_reset", 16'd2, 16'hFFFF, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b1);

    // Randomized traffic with random valid gaps and consumer stalls
    got_cnt = 0;
    fork
      begin : drv
        int g;
        for (int i = 0; i < NRAND; i++) begin
          valid = 1'b0;
          repeat ($urandom_range(0, 2)) tick();
          a  = 16'($urandom_range(0, 65535));
          b  = 16'($urandom_range(0, 65535));
          an = 1'($urandom_range(0, 1));
          bn = 1'($urandom_range(0, 1));
          valid = 1'b1;
          g = 0;
          while (!ready && g < 1000) begin tick(); g++; end
          if (g >= 1000) check("rand_accept_timeout", 64'd1, 64'd0);
          exp_q.push_back({an | bn, model(a, b, an, bn)});
          tick();
          valid = 1'b0;
        end
      end
      begin : mon
        int cyc;
        logic [32:0] e;
        cyc = 0;
        while (got_cnt < NRAND && cyc < 90000) begin
          rdy = ($urandom_range(0, 3) != 0);
          if (pvalid && rdy) begin
            if (exp_q.size() == 0) begin
              check("rand_extra", 64'd1, 64'd0);
            end else begin
              e = exp_q.pop_front();
              check("rand_prod", 64'(product), 64'(e[31:0]));
              check("rand_sgn", 64'(prod_signed), 64'(e[32]));
            end
            got_cnt++;
          end
          tick();
          cyc++;
        end
        rdy = 1'b0;
      end
    join
    check("rand_count", 64'(got_cnt), 64'(NRAND));
    check("rand_queue_empty", 64'(exp_q.size()), 64'd0);
    spurious = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pvalid) spurious++;
    end
    check("rand_no_dup", 64'(spurious), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
